// File: rtl/sdf_ctrl.sv
// Central sequencer for a radix-2^2 SDF FFT pipeline: per-stage butterfly, -j rotation
// and twiddle controls plus output framing, all derived from one enable delay line.
module sdf_ctrl #(
    parameter int N        = 64,
    parameter int MULT_LAT = 2,
    parameter int CNT_W    = 16,
    localparam int LOGN    = $clog2(N),
    localparam int NMUL    = LOGN / 2 - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_in,
    output logic [LOGN-1:0]      bf_sel,
    output logic [LOGN/2-1:0]    rot_en,
    output logic [NMUL-1:0]      tw_en,
    output logic [NMUL*LOGN-1:0] tw_addr,
    output logic                 out_valid,
    output logic                 out_start,
    output logic [LOGN-1:0]      out_index,
    output logic                 frame_err,
    output logic [CNT_W-1:0]     frames_done
);

    function automatic int stage_lag(input int k);
        int lag;
        lag = 0;
        for (int s = 0; s < k; s++) begin
            lag = lag + (N >> (s + 1)) + 1;
            if ((s % 2 == 1) && (s < LOGN - 1))
                lag = lag + MULT_LAT;
        end
        return lag;
    endfunction

    localparam int LAT = stage_lag(LOGN);

    // en_dly[i] holds enable_in from i+1 cycles ago
    logic [LAT-1:0]  en_dly;
    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] out_cnt;
    logic [LOGN-1:0] out_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_dly    <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            en_dly    <= {en_dly[LAT-2:0], enable_in};
            cnt       <= enable_in ? cnt + LOGN'(1) : '0;
            frame_err <= ~enable_in & (|cnt);
        end
    end

    // Stage 0 has zero lag, so its select can only be formed from the live enable
    assign bf_sel[0] = enable_in & cnt[LOGN-1];

    for (genvar k = 1; k < LOGN; k++) begin : g_stage
        localparam int LAG = stage_lag(k);

        logic [LOGN-1:0] c_q;
        logic [LOGN-1:0] c_next;
        logic            bf_q;

        assign c_next = en_dly[LAG-1] ? c_q + LOGN'(1) : '0;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                c_q  <= '0;
                bf_q <= 1'b0;
            end else begin
                c_q  <= c_next;
                bf_q <= en_dly[LAG-2] & c_next[LOGN-1-k];
            end
        end

        assign bf_sel[k] = bf_q;

        if (k % 2 == 1) begin : g_rot
            logic rot_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    rot_q <= 1'b0;
                else
                    rot_q <= en_dly[LAG-2] & (&c_next[LOGN-k -: 2]);
            end

            assign rot_en[(k-1)/2] = rot_q;
        end
    end

    for (genvar j = 0; j < NMUL; j++) begin : g_mul
        localparam int MLAG = stage_lag(2*j + 1) + (N >> (2*j + 2)) + 1;
        localparam int RW   = LOGN - 2 - 2*j;

        logic [LOGN-1:0] m_q;
        logic [LOGN-1:0] m_next;
        logic [LOGN-1:0] r;
        logic [1:0]      q;
        logic [LOGN-1:0] addr_next;
        logic            twe_q;
        logic [LOGN-1:0] twa_q;

        assign m_next = en_dly[MLAG-1] ? m_q + LOGN'(1) : '0;
        assign q      = m_next[LOGN-1-2*j -: 2];
        assign r      = m_next & LOGN'((1 << RW) - 1);
        // perm(0,1,2,3) = (0,2,1,3) is a swap of the two quadrant bits
        assign addr_next = LOGN'((r * LOGN'({q[0], q[1]})) << (2*j));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m_q   <= '0;
                twe_q <= 1'b0;
                twa_q <= '0;
            end else begin
                m_q   <= m_next;
                twe_q <= en_dly[MLAG-2];
                twa_q <= en_dly[MLAG-2] ? addr_next : '0;
            end
        end

        assign tw_en[j]                 = twe_q;
        assign tw_addr[j*LOGN +: LOGN]  = twa_q;
    end

    assign out_valid    = en_dly[LAT-1];
    assign out_cnt_next = out_valid ? out_cnt + LOGN'(1) : '0;
    assign out_index    = out_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt     <= '0;
            out_start   <= 1'b0;
            frames_done <= '0;
        end else begin
            out_cnt   <= out_cnt_next;
            out_start <= en_dly[LAT-2] & ~(|out_cnt_next);
            if (out_valid & (&out_cnt) & ~(&frames_done))
                frames_done <= frames_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sdf_ctrl.sv
// Scoreboard bench for sdf_ctrl at N=16: stimulus pushes expected per-cycle controls,
// output indices and twiddle addresses; a negedge monitor pops and compares them.
module tb_sdf_ctrl;

    localparam int N        = 16;
    localparam int MULT_LAT = 2;
    localparam int CNT_W    = 2;
    localparam int LOGN     = 4;
    localparam int L        = 21;
    localparam int MLAG0    = 14;
    localparam int FD_MAX   = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                enable_in = 1'b0;
    logic [LOGN-1:0]     bf_sel;
    logic [1:0]          rot_en;
    logic [0:0]          tw_en;
    logic [LOGN-1:0]     tw_addr;
    logic                out_valid;
    logic                out_start;
    logic [LOGN-1:0]     out_index;
    logic                frame_err;
    logic [CNT_W-1:0]    frames_done;

    sdf_ctrl #(.N(N), .MULT_LAT(MULT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .enable_in(enable_in),
        .bf_sel(bf_sel), .rot_en(rot_en), .tw_en(tw_en), .tw_addr(tw_addr),
        .out_valid(out_valid), .out_start(out_start), .out_index(out_index),
        .frame_err(frame_err), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc; int bf; int rot; int twe; int ov; int st; int fe; int fd;
    } trace_t;

    trace_t trace_q[$];
    int     out_q[$];
    int     tw_q[$];
    trace_t mon_e;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     mon_on = 1'b0;
    bit     en_pat [0:255];
    int     cntm [0:255];
    int     lag_tab [0:3] = '{0, 9, 16, 19};
    // tw_addr for multiplier 0 indexed by m, worked out by hand from r * perm(q)
    int     tw_tab [0:15] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};

    task automatic checkOutput(input string name, input int cyc,
                               input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    function automatic bit en_at(input int t);
        if (t < 0 || t > 255) return 1'b0;
        return en_pat[t];
    endfunction

    function automatic int cnt_at(input int t);
        if (t < 0 || t > 255) return 0;
        return cntm[t];
    endfunction

    task automatic clear_pattern();
        for (int i = 0; i < 256; i++) begin
            en_pat[i] = 1'b0;
            cntm[i]   = 0;
        end
    endtask

    task automatic set_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) en_pat[i] = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        enable_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input int T);
        int     fdm;
        int     bf;
        int     rot;
        int     c;
        trace_t e;
        fdm = 0;
        cntm[0] = 0;
        for (int t = 1; t < T; t++)
            cntm[t] = en_pat[t-1] ? (cntm[t-1] + 1) % N : 0;
        for (int t = 0; t < T; t++) begin
            bf  = 0;
            rot = 0;
            for (int k = 0; k < LOGN; k++)
                if (en_at(t - lag_tab[k]) && (((cnt_at(t - lag_tab[k]) >> (LOGN-1-k)) & 1) == 1))
                    bf = bf | (1 << k);
            for (int j = 0; j < 2; j++) begin
                c = cnt_at(t - lag_tab[2*j+1]);
                if (en_at(t - lag_tab[2*j+1]) && (((c >> (2 - 2*j)) & 3) == 3))
                    rot = rot | (1 << j);
            end
            e.cyc = t;
            e.bf  = bf;
            e.rot = rot;
            e.twe = int'(en_at(t - MLAG0));
            e.ov  = int'(en_at(t - L));
            e.st  = (en_at(t - L) && cnt_at(t - L) == 0) ? 1 : 0;
            e.fe  = (!en_at(t - 1) && cnt_at(t - 1) != 0) ? 1 : 0;
            e.fd  = fdm;
            trace_q.push_back(e);
            if (en_at(t - L)) begin
                out_q.push_back(cnt_at(t - L));
                if (cnt_at(t - L) == N - 1 && fdm < FD_MAX) fdm++;
            end
            if (en_at(t - MLAG0))
                tw_q.push_back(tw_tab[cnt_at(t - MLAG0)]);
        end

        @(posedge clk); #1;
        mon_on    = 1'b1;
        enable_in = en_pat[0];
        for (int t = 1; t < T; t++) begin
            @(posedge clk); #1;
            enable_in = en_pat[t];
        end
        @(posedge clk); #1;
        mon_on    = 1'b0;
        enable_in = 1'b0;
        checkOutput("trace_q_drained", T, trace_q.size(), 0);
        checkOutput("out_q_drained", T, out_q.size(), 0);
        checkOutput("tw_q_drained", T, tw_q.size(), 0);
        trace_q.delete();
        out_q.delete();
        tw_q.delete();
    endtask

    task automatic resetTest();
        do_reset();
        @(posedge clk); #1;
        enable_in = 1'b1;
        repeat (29) begin
            @(posedge clk); #1;
        end
        #2;
        checkOutput("pre_reset_out_valid", 29, out_valid, 1);
        checkOutput("pre_reset_out_index", 29, out_index, 8);
        checkOutput("pre_reset_tw_en", 29, tw_en, 1);
        checkOutput("pre_reset_bf_sel0", 29, bf_sel[0], 1);
        rst = 1'b1;
        #1;
        checkOutput("reset_bf_sel", 29, bf_sel, 0);
        checkOutput("reset_rot_en", 29, rot_en, 0);
        checkOutput("reset_tw_en", 29, tw_en, 0);
        checkOutput("reset_tw_addr", 29, tw_addr, 0);
        checkOutput("reset_out_valid", 29, out_valid, 0);
        checkOutput("reset_out_start", 29, out_start, 0);
        checkOutput("reset_out_index", 29, out_index, 0);
        checkOutput("reset_frame_err", 29, frame_err, 0);
        checkOutput("reset_frames_done", 29, frames_done, 0);
        @(negedge clk);
        enable_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (trace_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL trace_underrun: got empty queue, expected a cycle entry");
            end else begin
                mon_e = trace_q.pop_front();
                checkOutput("bf_sel", mon_e.cyc, bf_sel, mon_e.bf);
                checkOutput("rot_en", mon_e.cyc, rot_en, mon_e.rot);
                checkOutput("tw_en", mon_e.cyc, tw_en, mon_e.twe);
                checkOutput("out_valid", mon_e.cyc, out_valid, mon_e.ov);
                checkOutput("out_start", mon_e.cyc, out_start, mon_e.st);
                checkOutput("frame_err", mon_e.cyc, frame_err, mon_e.fe);
                checkOutput("frames_done", mon_e.cyc, frames_done, mon_e.fd);
                if (out_valid === 1'b1) begin
                    if (out_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL out_underrun at cycle %0d: got unexpected out_valid", mon_e.cyc);
                    end else begin
                        checkOutput("out_index", mon_e.cyc, out_index, out_q.pop_front());
                    end
                end
                if (tw_en[0] === 1'b1) begin
                    if (tw_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("[TB] FAIL tw_underrun at cycle %0d: got unexpected tw_en", mon_e.cyc);
                    end else begin
                        checkOutput("tw_addr", mon_e.cyc, tw_addr, tw_q.pop_front());
                    end
                end else begin
                    checkOutput("tw_addr_idle", mon_e.cyc, tw_addr, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetTest();

        $display("[TB] single frame");
        clear_pattern(); set_range(0, 15);
        do_reset(); applyStimulus(40);

        $display("[TB] back-to-back frames");
        clear_pattern(); set_range(0, 31);
        do_reset(); applyStimulus(56);

        $display("[TB] partial frame then full frame");
        clear_pattern(); set_range(0, 9); set_range(12, 27);
        do_reset(); applyStimulus(52);

        $display("[TB] frame_err coinciding with out_start, restart after one-cycle gap");
        clear_pattern(); set_range(1, 16); set_range(18, 20);
        do_reset(); applyStimulus(48);

        $display("[TB] frames_done saturation");
        clear_pattern(); set_range(0, 63);
        do_reset(); applyStimulus(90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
